// File: rtl/execute_stage_p.sv
// ----------------------------------------------------------------------------
// execute_stage_p
//   Y86 execute stage with the E->M pipeline register folded in.
//   - Computes e_valE from aluA/aluB selected by icode, with OPq ifun picking
//     the ALU function (add, B-A, and, xor, optional signed multiply).
//   - Evaluates jXX / cmovXX conditions from the registered CC {ZF,SF,OF}.
//   - Writes CC for OPq only while the memory and writeback stages are AOK.
//   - OPq ifun 4 (MUL_EN=1) runs an iterative shift-add multiply; e_busy
//     asks the hazard unit to stall F/D/E and bubbles the M register.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   E_*                 instruction fields held in the D/E register
//   m_stat, W_stat      downstream status, gates CC writes
//   M_stall, M_bubble   M register control from the hazard unit
//   e_valE, e_cnd       combinational execute results
//   e_dstE              E_dstE, or F for a cmovXX whose condition fails
//   e_busy              multiply in progress
//   M_*                 E/M pipeline register outputs
//   cc_out              registered {ZF,SF,OF}
//   mul_state           multiply FSM state (0 IDLE, 1 MUL, 2 DONE)
//
// Handshake: e_busy is the only flow-control signal this block raises. While
// it is high the result is not valid, CC is not written and the M register
// loads a bubble; E_* must be held stable by the hazard unit. The result is
// valid in the cycle e_busy falls (DONE) and is consumed on the next edge
// that M is not stalled.
// ----------------------------------------------------------------------------
module execute_stage_p #(
    parameter int W      = 64,
    parameter bit MUL_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   E_stat,
    input  logic [3:0]   E_icode,
    input  logic [3:0]   E_ifun,
    input  logic [W-1:0] E_valC,
    input  logic [W-1:0] E_valA,
    input  logic [W-1:0] E_valB,
    input  logic [3:0]   E_dstE,
    input  logic [3:0]   E_dstM,
    input  logic [2:0]   m_stat,
    input  logic [2:0]   W_stat,
    input  logic         M_stall,
    input  logic         M_bubble,
    output logic [W-1:0] e_valE,
    output logic         e_cnd,
    output logic [3:0]   e_dstE,
    output logic         e_busy,
    output logic [2:0]   M_stat,
    output logic [3:0]   M_icode,
    output logic         M_cnd,
    output logic [W-1:0] M_valE,
    output logic [W-1:0] M_valA,
    output logic [3:0]   M_dstE,
    output logic [3:0]   M_dstM,
    output logic [2:0]   cc_out,
    output logic [1:0]   mul_state
);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;
    localparam logic [2:0] STAT_AOK = 3'd1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int          CW       = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [W-1:0] PLUS8   = W'(8);
    localparam logic [W-1:0] MINUS8  = {{(W-4){1'b1}}, 4'b1000};

    // ------------------------------------------------------------------
    // Operand selection and single-cycle ALU
    // ------------------------------------------------------------------
    logic         is_opq;
    logic         is_mul;
    logic         alu_ok;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [1:0]   alu_fn;
    logic [W-1:0] alu_r;
    logic         alu_of;

    assign is_opq = (E_icode == I_OPQ);
    assign is_mul = MUL_EN && is_opq && (E_ifun == 4'd4);

    always_comb begin
        alu_ok = 1'b1;
        alu_a  = '0;
        alu_b  = E_valB;
        case (E_icode)
            I_RRMOVQ:         begin alu_a = E_valA; alu_b = '0; end
            I_IRMOVQ:         begin alu_a = E_valC; alu_b = '0; end
            I_RMMOVQ,
            I_MRMOVQ:         alu_a = E_valC;
            I_OPQ:            alu_a = E_valA;
            I_CALL, I_PUSHQ:  alu_a = MINUS8;
            I_RET, I_POPQ:    alu_a = PLUS8;
            default:          alu_ok = 1'b0;
        endcase
    end

    // ifun 4 (without MUL_EN) and ifun >4 fall back to add.
    assign alu_fn = (is_opq && E_ifun < 4'd4) ? E_ifun[1:0] : 2'd0;

    always_comb begin
        alu_r  = '0;
        alu_of = 1'b0;
        case (alu_fn)
            2'd0: begin
                alu_r  = alu_b + alu_a;
                alu_of = (alu_a[W-1] == alu_b[W-1]) && (alu_r[W-1] != alu_a[W-1]);
            end
            2'd1: begin
                alu_r  = alu_b - alu_a;
                alu_of = (alu_a[W-1] != alu_b[W-1]) && (alu_r[W-1] != alu_b[W-1]);
            end
            2'd2: alu_r = alu_b & alu_a;
            default: alu_r = alu_b ^ alu_a;
        endcase
        if (!alu_ok) begin
            alu_r  = '0;
            alu_of = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Iterative multiply: unsigned shift-add on magnitudes, sign fixed up
    // at the end. acc holds {partial product high, remaining multiplier}.
    // ------------------------------------------------------------------
    logic [1:0]     state_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   mcand_q;
    logic [2*W-1:0] acc_q;
    logic           neg_q;

    logic [W-1:0]   a_abs;
    logic [W-1:0]   b_abs;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] acc_nxt;
    logic [2*W-1:0] prod_s;
    logic           mul_of;

    assign a_abs   = E_valA[W-1] ? (~E_valA + 1'b1) : E_valA;
    assign b_abs   = E_valB[W-1] ? (~E_valB + 1'b1) : E_valB;
    assign mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
    assign acc_nxt = {mul_sum, acc_q[W-1:1]};
    assign prod_s  = neg_q ? (~acc_q + 1'b1) : acc_q;
    // Overflow when the full product does not survive truncation to W bits.
    assign mul_of  = (prod_s[2*W-1:W] != {W{prod_s[W-1]}});

    assign e_busy    = (state_q == S_MUL) || (state_q == S_IDLE && is_mul);
    assign mul_state = state_q;

    // ------------------------------------------------------------------
    // Result, condition codes, condition evaluation
    // ------------------------------------------------------------------
    logic       of_now;
    logic       cc_we;
    logic [2:0] cc_q;
    logic       cc_zf;
    logic       cc_sf;
    logic       cc_of;
    logic       lt;

    always_comb begin
        e_valE = alu_r;
        of_now = alu_of;
        if (state_q == S_DONE) begin
            e_valE = prod_s[W-1:0];
            of_now = mul_of;
        end else if (e_busy) begin
            e_valE = '0;
            of_now = 1'b0;
        end
    end

    // A multiply result writes CC only on the edge that leaves DONE, so a
    // stalled DONE does not rewrite it every cycle.
    assign cc_we = is_opq && (m_stat == STAT_AOK) && (W_stat == STAT_AOK) &&
                   ((state_q == S_DONE) ? !M_stall : (state_q == S_IDLE && !is_mul));

    assign cc_zf  = cc_q[2];
    assign cc_sf  = cc_q[1];
    assign cc_of  = cc_q[0];
    assign lt     = cc_sf ^ cc_of;
    assign cc_out = cc_q;

    always_comb begin
        e_cnd = 1'b0;
        if (E_icode == I_JXX || E_icode == I_RRMOVQ) begin
            case (E_ifun)
                4'd0:    e_cnd = 1'b1;
                4'd1:    e_cnd = lt | cc_zf;
                4'd2:    e_cnd = lt;
                4'd3:    e_cnd = cc_zf;
                4'd4:    e_cnd = !cc_zf;
                4'd5:    e_cnd = !lt;
                4'd6:    e_cnd = !lt && !cc_zf;
                default: e_cnd = 1'b0;
            endcase
        end
    end

    assign e_dstE = (E_icode == I_RRMOVQ && !e_cnd) ? R_NONE : E_dstE;

    // ------------------------------------------------------------------
    // Sequential: FSM, multiply datapath, CC
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            cc_q    <= 3'b100;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_mul) begin
                        mcand_q <= a_abs;
                        acc_q   <= {{W{1'b0}}, b_abs};
                        neg_q   <= E_valA[W-1] ^ E_valB[W-1];
                        cnt_q   <= '0;
                        state_q <= S_MUL;
                    end
                end
                S_MUL: begin
                    acc_q <= acc_nxt;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (!M_stall) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            if (cc_we) begin
                cc_q <= {(e_valE == '0), e_valE[W-1], of_now};
            end
        end
    end

    // ------------------------------------------------------------------
    // E/M pipeline register: rst > stall > bubble > busy-bubble > load
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || (!M_stall && (M_bubble || e_busy))) begin
            M_stat  <= STAT_AOK;
            M_icode <= I_NOP;
            M_cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= R_NONE;
            M_dstM  <= R_NONE;
        end else if (!M_stall) begin
            M_stat  <= E_stat;
            M_icode <= E_icode;
            M_cnd   <= e_cnd;
            M_valE  <= e_valE;
            M_valA  <= E_valA;
            M_dstE  <= e_dstE;
            M_dstM  <= E_dstM;
        end
    end

endmodule

// File: tb/tb_execute_stage_p.sv
// ----------------------------------------------------------------------------
// tb_execute_stage_p
//   Directed and randomized checks of execute_stage_p (W=16) against an
//   integer-arithmetic reference model of the Y86 execute rules.
// ----------------------------------------------------------------------------
module tb_execute_stage_p;

    localparam int W = 16;
    localparam int MW = 3 + 4 + 1 + W + 4 + 4;   // M reg minus valE

    logic         clk;
    logic         rst;
    logic [2:0]   E_stat;
    logic [3:0]   E_icode;
    logic [3:0]   E_ifun;
    logic [W-1:0] E_valC;
    logic [W-1:0] E_valA;
    logic [W-1:0] E_valB;
    logic [3:0]   E_dstE;
    logic [3:0]   E_dstM;
    logic [2:0]   m_stat;
    logic [2:0]   W_stat;
    logic         M_stall;
    logic         M_bubble;
    logic [W-1:0] e_valE;
    logic         e_cnd;
    logic [3:0]   e_dstE;
    logic         e_busy;
    logic [2:0]   M_stat;
    logic [3:0]   M_icode;
    logic         M_cnd;
    logic [W-1:0] M_valE;
    logic [W-1:0] M_valA;
    logic [3:0]   M_dstE;
    logic [3:0]   M_dstM;
    logic [2:0]   cc_out;
    logic [1:0]   mul_state;

    int           n_checks;
    int           n_fail;
    logic [2:0]   exp_cc;
    logic [W-1:0] exp_q[$];

    execute_stage_p #(.W(W), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM),
        .m_stat(m_stat), .W_stat(W_stat),
        .M_stall(M_stall), .M_bubble(M_bubble),
        .e_valE(e_valE), .e_cnd(e_cnd), .e_dstE(e_dstE), .e_busy(e_busy),
        .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd), .M_valE(M_valE),
        .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .cc_out(cc_out), .mul_state(mul_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver ----------------
    task automatic set_e(input logic [2:0] stat, input logic [3:0] icode,
                         input logic [3:0] ifun, input logic [W-1:0] valc,
                         input logic [W-1:0] vala, input logic [W-1:0] valb,
                         input logic [3:0] dste, input logic [3:0] dstm);
        E_stat  = stat;
        E_icode = icode;
        E_ifun  = ifun;
        E_valC  = valc;
        E_valA  = vala;
        E_valB  = valb;
        E_dstE  = dste;
        E_dstM  = dstm;
    endtask

    // ---------------- reference model ----------------
    // Returns {OF, valE}; computed on sign-extended integers, OF = result
    // outside the W-bit signed range.
    function automatic logic [W:0] model_alu(input logic [3:0] icode, input logic [3:0] ifun,
                                             input logic [W-1:0] va, input logic [W-1:0] vb,
                                             input logic [W-1:0] vc);
        longint a, b, c, r, maxp, minn;
        bit     chk;
        a    = $signed(va);
        b    = $signed(vb);
        c    = $signed(vc);
        maxp = (longint'(1) << (W - 1)) - 1;
        minn = -maxp - 1;
        r    = 0;
        chk  = 1'b0;
        case (icode)
            4'h2: r = a;
            4'h3: r = c;
            4'h4, 4'h5: r = b + c;
            4'h6: begin
                case (ifun)
                    4'd1: begin r = b - a; chk = 1'b1; end
                    4'd2: r = a & b;
                    4'd3: r = a ^ b;
                    4'd4: begin r = a * b; chk = 1'b1; end
                    default: begin r = a + b; chk = 1'b1; end
                endcase
            end
            4'h8, 4'hA: r = b - 8;
            4'h9, 4'hB: r = b + 8;
            default: r = 0;
        endcase
        return {chk && (r > maxp || r < minn), r[W-1:0]};
    endfunction

    function automatic logic [2:0] model_cc(input logic [W:0] res);
        return {res[W-1:0] == '0, res[W-1], res[W]};
    endfunction

    function automatic logic model_cnd(input logic [3:0] icode, input logic [3:0] ifun,
                                       input logic [2:0] cc);
        bit zf, less;
        zf   = cc[2];
        less = (cc[1] != cc[0]);
        if (icode != 4'h7 && icode != 4'h2) return 1'b0;
        case (ifun)
            4'd0: return 1'b1;
            4'd1: return less || zf;
            4'd2: return less;
            4'd3: return zf;
            4'd4: return !zf;
            4'd5: return !less;
            4'd6: return !less && !zf;
            default: return 1'b0;
        endcase
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; M_stall = 1'b0; M_bubble = 1'b0; m_stat = 3'd1; W_stat = 3'd1;
        set_e(3'd1, 4'h1, 4'h0, '0, '0, '0, 4'hF, 4'hF);
        tick(); tick();
        rst = 1'b0;
        #1;
        exp_cc = 3'b100;
        n_checks++; if (cc_out !== 3'b100) begin n_fail++; $display("FAIL reset_cc got=%b exp=100", cc_out); end
        n_checks++; if (e_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", e_busy); end
        n_checks++;
        if ({M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM} !==
            {3'd1, 4'h1, 1'b0, {W{1'b0}}, {W{1'b0}}, 4'hF, 4'hF}) begin
            n_fail++;
            $display("FAIL reset_mreg got stat=%0d icode=%h cnd=%b valE=%h valA=%h dstE=%h dstM=%h exp bubble",
                     M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM);
        end
    endtask

    task automatic test_sub_zero();
        logic [W:0] r;
        r = model_alu(4'h6, 4'd1, 16'd5, 16'd5, '0);
        set_e(3'd1, 4'h6, 4'd1, '0, 16'd5, 16'd5, 4'h3, 4'hF);
        #1;
        n_checks++; if (e_valE !== r[W-1:0]) begin n_fail++; $display("FAIL sub_valE got=%h exp=%h", e_valE, r[W-1:0]); end
        tick();
        exp_cc = model_cc(r);
        n_checks++; if (cc_out !== exp_cc) begin n_fail++; $display("FAIL sub_cc got=%b exp=%b", cc_out, exp_cc); end
        n_checks++; if (M_valE !== r[W-1:0] || M_dstE !== 4'h3) begin
            n_fail++; $display("FAIL sub_mreg got valE=%h dstE=%h exp valE=%h dstE=3", M_valE, M_dstE, r[W-1:0]); end
        set_e(3'd1, 4'h7, 4'd4, '0, '0, '0, 4'hF, 4'hF);
        #1;
        n_checks++; if (e_cnd !== model_cnd(4'h7, 4'd4, exp_cc)) begin
            n_fail++; $display("FAIL jne_cnd got=%b exp=%b", e_cnd, model_cnd(4'h7, 4'd4, exp_cc)); end
    endtask

    task automatic test_add_overflow();
        logic [W:0] r;
        r = model_alu(4'h6, 4'd0, 16'h7fff, 16'h0001, '0);
        set_e(3'd1, 4'h6, 4'd0, '0, 16'h7fff, 16'h0001, 4'h4, 4'hF);
        #1;
        n_checks++; if (e_valE !== r[W-1:0]) begin n_fail++; $display("FAIL addov_valE got=%h exp=%h", e_valE, r[W-1:0]); end
        tick();
        exp_cc = model_cc(r);
        n_checks++; if (cc_out !== exp_cc) begin n_fail++; $display("FAIL addov_cc got=%b exp=%b", cc_out, exp_cc); end
        set_e(3'd1, 4'h7, 4'd2, '0, '0, '0, 4'hF, 4'hF);
        #1;
        n_checks++; if (e_cnd !== model_cnd(4'h7, 4'd2, exp_cc)) begin
            n_fail++; $display("FAIL jl_cnd got=%b exp=%b", e_cnd, model_cnd(4'h7, 4'd2, exp_cc)); end
    endtask

    task automatic test_stat_gate();
        m_stat = 3'd3;
        set_e(3'd2, 4'h6, 4'd0, '0, 16'd1, 16'd1, 4'h4, 4'hF);
        tick();
        n_checks++; if (cc_out !== exp_cc) begin n_fail++; $display("FAIL gate_m_cc got=%b exp=%b", cc_out, exp_cc); end
        n_checks++; if (M_stat !== 3'd2) begin n_fail++; $display("FAIL gate_mstat got=%0d exp=2", M_stat); end
        m_stat = 3'd1; W_stat = 3'd4;
        set_e(3'd1, 4'h6, 4'd1, '0, 16'd1, 16'd1, 4'h4, 4'hF);
        tick();
        n_checks++; if (cc_out !== exp_cc) begin n_fail++; $display("FAIL gate_w_cc got=%b exp=%b", cc_out, exp_cc); end
        W_stat = 3'd1;
    endtask

    task automatic test_cmov();
        logic [W:0] r;
        r = model_alu(4'h6, 4'd1, 16'd1, 16'd0, '0);
        set_e(3'd1, 4'h6, 4'd1, '0, 16'd1, 16'd0, 4'h4, 4'hF);
        tick();
        exp_cc = model_cc(r);
        n_checks++; if (cc_out !== exp_cc) begin n_fail++; $display("FAIL cmov_setcc got=%b exp=%b", cc_out, exp_cc); end
        set_e(3'd1, 4'h2, 4'd2, '0, 16'h1234, '0, 4'h5, 4'hF);
        #1;
        n_checks++; if (e_cnd !== 1'b1 || e_dstE !== 4'h5 || e_valE !== 16'h1234) begin
            n_fail++; $display("FAIL cmovl_taken got cnd=%b dstE=%h valE=%h exp 1 5 1234", e_cnd, e_dstE, e_valE); end
        r = model_alu(4'h6, 4'd0, 16'd1, 16'd1, '0);
        set_e(3'd1, 4'h6, 4'd0, '0, 16'd1, 16'd1, 4'h4, 4'hF);
        tick();
        exp_cc = model_cc(r);
        n_checks++; if (cc_out !== exp_cc) begin n_fail++; $display("FAIL cmov_clrcc got=%b exp=%b", cc_out, exp_cc); end
        set_e(3'd1, 4'h2, 4'd2, '0, 16'h1234, '0, 4'h5, 4'hF);
        #1;
        n_checks++; if (e_cnd !== 1'b0 || e_dstE !== 4'hF) begin
            n_fail++; $display("FAIL cmovl_not_taken got cnd=%b dstE=%h exp 0 F", e_cnd, e_dstE); end
    endtask

    task automatic test_mul();
        logic [W-1:0] ma[5];
        logic [W-1:0] mb[5];
        logic [W:0]   r;
        int           busy_cycles;
        int           guard;
        ma[0] = -16'sd3;   mb[0] = 16'd7;
        ma[1] = 16'h8000;  mb[1] = 16'hffff;
        ma[2] = 16'd255;   mb[2] = 16'd255;
        ma[3] = W'($urandom); mb[3] = W'($urandom_range(0, 255));
        ma[4] = W'($urandom); mb[4] = 16'd0;
        for (int i = 0; i < 5; i++) begin
            r = model_alu(4'h6, 4'd4, ma[i], mb[i], '0);
            set_e(3'd1, 4'h6, 4'd4, '0, ma[i], mb[i], 4'h6, 4'hF);
            #1;
            n_checks++; if (e_busy !== 1'b1) begin n_fail++; $display("FAIL mul%0d_busy_start got=%b exp=1", i, e_busy); end
            busy_cycles = 1;
            guard = 0;
            while (e_busy === 1'b1 && guard < 3 * W) begin
                tick();
                guard++;
                if (e_busy === 1'b1) begin
                    busy_cycles++;
                    n_checks++; if (M_icode !== 4'h1 || M_valE !== '0) begin
                        n_fail++; $display("FAIL mul%0d_bubble got icode=%h valE=%h exp 1 0", i, M_icode, M_valE); end
                end
            end
            n_checks++; if (busy_cycles != W + 1) begin
                n_fail++; $display("FAIL mul%0d_busy_len got=%0d exp=%0d", i, busy_cycles, W + 1); end
            n_checks++; if (e_valE !== r[W-1:0]) begin
                n_fail++; $display("FAIL mul%0d_valE got=%h exp=%h", i, e_valE, r[W-1:0]); end
            tick();
            set_e(3'd1, 4'h1, 4'h0, '0, '0, '0, 4'hF, 4'hF);
            exp_cc = model_cc(r);
            n_checks++; if (M_valE !== r[W-1:0] || M_icode !== 4'h6 || M_dstE !== 4'h6) begin
                n_fail++; $display("FAIL mul%0d_mreg got valE=%h icode=%h dstE=%h exp valE=%h icode=6 dstE=6",
                                   i, M_valE, M_icode, M_dstE, r[W-1:0]); end
            n_checks++; if (cc_out !== exp_cc) begin
                n_fail++; $display("FAIL mul%0d_cc got=%b exp=%b", i, cc_out, exp_cc); end
        end
    endtask

    task automatic test_mul_stall_done();
        logic [W:0] r;
        int         guard;
        r = model_alu(4'h6, 4'd4, 16'd100, -16'sd200, '0);
        set_e(3'd1, 4'h6, 4'd4, '0, 16'd100, -16'sd200, 4'h7, 4'hF);
        guard = 0;
        #1;
        while (e_busy === 1'b1 && guard < 3 * W) begin
            tick();
            guard++;
        end
        n_checks++; if (guard != W + 1) begin n_fail++; $display("FAIL stall_busy_len got=%0d exp=%0d", guard, W + 1); end
        M_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (e_busy !== 1'b0 || e_valE !== r[W-1:0] || M_icode !== 4'h1) begin
                n_fail++; $display("FAIL stall_hold%0d got busy=%b valE=%h Micode=%h exp 0 %h 1",
                                   k, e_busy, e_valE, M_icode, r[W-1:0]); end
        end
        M_stall = 1'b0;
        tick();
        set_e(3'd1, 4'h1, 4'h0, '0, '0, '0, 4'hF, 4'hF);
        exp_cc = model_cc(r);
        n_checks++; if (M_valE !== r[W-1:0] || M_dstE !== 4'h7) begin
            n_fail++; $display("FAIL stall_release_mreg got valE=%h dstE=%h exp %h 7", M_valE, M_dstE, r[W-1:0]); end
        n_checks++; if (cc_out !== exp_cc) begin n_fail++; $display("FAIL stall_release_cc got=%b exp=%b", cc_out, exp_cc); end
    endtask

    task automatic test_reset_mid_mul();
        set_e(3'd1, 4'h6, 4'd0, '0, 16'd1, 16'd1, 4'h4, 4'hF);
        tick();
        set_e(3'd1, 4'h6, 4'd4, '0, -16'sd3, 16'd7, 4'h6, 4'hF);
        for (int k = 0; k < 5; k++) tick();
        rst = 1'b1;
        set_e(3'd1, 4'h1, 4'h0, '0, '0, '0, 4'hF, 4'hF);
        tick();
        rst = 1'b0;
        exp_cc = 3'b100;
        n_checks++; if (e_busy !== 1'b0) begin n_fail++; $display("FAIL rstmul_busy got=%b exp=0", e_busy); end
        n_checks++; if (M_icode !== 4'h1 || M_valE !== '0 || M_dstE !== 4'hF) begin
            n_fail++; $display("FAIL rstmul_mreg got icode=%h valE=%h dstE=%h exp 1 0 F", M_icode, M_valE, M_dstE); end
        n_checks++; if (cc_out !== exp_cc) begin n_fail++; $display("FAIL rstmul_cc got=%b exp=%b", cc_out, exp_cc); end
    endtask

    task automatic test_random();
        logic [MW-1:0] exp_m;
        logic [W-1:0]  exp_valE_reg;
        logic [W:0]    r;
        logic [3:0]    icode, ifun, dste, dstm;
        logic [2:0]    stat;
        logic [W-1:0]  va, vb, vc;
        logic          cnd;
        logic [3:0]    exp_dste;
        logic [W-1:0]  got_q;
        M_stall = 1'b0; M_bubble = 1'b0;
        set_e(3'd1, 4'h1, 4'h0, '0, '0, '0, 4'hF, 4'hF);
        tick();
        exp_m = {3'd1, 4'h1, 1'b0, {W{1'b0}}, 4'hF, 4'hF};
        exp_valE_reg = '0;
        for (int i = 0; i < 300; i++) begin
            icode = 4'($urandom_range(0, 15));
            ifun  = (icode == 4'h2 || icode == 4'h7) ? 4'($urandom_range(0, 8)) : 4'($urandom_range(0, 15));
            if (icode == 4'h6 && ifun == 4'd4) ifun = 4'd5;
            stat = 3'($urandom_range(1, 4));
            va = ($urandom_range(0, 5) == 0) ? 16'h7fff : W'($urandom);
            vb = ($urandom_range(0, 5) == 0) ? 16'h8000 : W'($urandom);
            vc = W'($urandom);
            dste = 4'($urandom_range(0, 15));
            dstm = 4'($urandom_range(0, 15));
            m_stat   = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'd1;
            W_stat   = ($urandom_range(0, 7) == 0) ? 3'd4 : 3'd1;
            M_stall  = ($urandom_range(0, 7) == 0);
            M_bubble = ($urandom_range(0, 7) == 0);
            set_e(stat, icode, ifun, vc, va, vb, dste, dstm);
            r   = model_alu(icode, ifun, va, vb, vc);
            cnd = model_cnd(icode, ifun, exp_cc);
            exp_dste = (icode == 4'h2 && !cnd) ? 4'hF : dste;
            #1;
            n_checks++; if (e_valE !== r[W-1:0] || e_cnd !== cnd || e_dstE !== exp_dste) begin
                n_fail++; $display("FAIL rnd%0d_comb icode=%h ifun=%h got valE=%h cnd=%b dstE=%h exp valE=%h cnd=%b dstE=%h",
                                   i, icode, ifun, e_valE, e_cnd, e_dstE, r[W-1:0], cnd, exp_dste); end
            if (!M_stall) begin
                if (M_bubble) begin
                    exp_m = {3'd1, 4'h1, 1'b0, {W{1'b0}}, 4'hF, 4'hF};
                    exp_valE_reg = '0;
                end else begin
                    exp_m = {stat, icode, cnd, va, exp_dste, dstm};
                    exp_valE_reg = r[W-1:0];
                end
            end
            exp_q.push_back(exp_valE_reg);
            if (icode == 4'h6 && m_stat == 3'd1 && W_stat == 3'd1) exp_cc = model_cc(r);
            tick();
            got_q = exp_q.pop_front();
            n_checks++; if ({M_stat, M_icode, M_cnd, M_valA, M_dstE, M_dstM} !== exp_m) begin
                n_fail++; $display("FAIL rnd%0d_mreg got=%h exp=%h", i,
                                   {M_stat, M_icode, M_cnd, M_valA, M_dstE, M_dstM}, exp_m); end
            n_checks++; if (M_valE !== got_q) begin
                n_fail++; $display("FAIL rnd%0d_mvalE got=%h exp=%h", i, M_valE, got_q); end
            n_checks++; if (cc_out !== exp_cc) begin
                n_fail++; $display("FAIL rnd%0d_cc got=%b exp=%b", i, cc_out, exp_cc); end
        end
        M_stall = 1'b0; M_bubble = 1'b0; m_stat = 3'd1; W_stat = 3'd1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_sub_zero();
        test_add_overflow();
        test_stat_gate();
        test_cmov();
        test_mul();
        test_mul_stall_done();
        test_reset_mid_mul();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
